// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that drains NUM_REQ upstream FIFOs into one downstream
// FIFO. One requester at a time holds the grant. Each grant moves at most
// MAX_BURST words with paired pop/push strobes, then hands priority to the
// next index.
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_pop,
  input  logic                            out_full,
  output logic                            out_push,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_r,     state_nxt_s;
  logic [ID_W-1:0] rr_ptr_r,    rr_ptr_nxt_s;
  logic [ID_W-1:0] grant_id_r,  grant_id_nxt_s;
  logic [3:0]      burst_cnt_r, burst_cnt_nxt_s;
  logic [ID_W-1:0] sel_id_s;
  logic            sel_found_s;
  logic [ID_W-1:0] id_inc_s;
  logic            xfer_s;

  // Pick the first non-empty requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] cand;
    sel_id_s    = rr_ptr_r;
    sel_found_s = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!sel_found_s && !req_empty[cand[ID_W-1:0]]) begin
        sel_found_s = 1'b1;
        sel_id_s    = cand[ID_W-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Priority successor of the current grant, wrapping from NUM_REQ-1 to 0.
  always_comb begin
    id_inc_s = '0;
    if (grant_id_r == ID_W'(NUM_REQ - 1)) begin
      id_inc_s = '0;
    end else begin
      id_inc_s = grant_id_r + ID_W'(1);
    end
  end

  // Transfer strobes are combinational; a reset cycle masks them so nothing moves mid-reset.
  always_comb begin
    req_pop  = '0;
    out_push = 1'b0;
    out_data = '0;
    xfer_s   = (state_r == ST_GRANT) && !rst && !req_empty[grant_id_r] && !out_full;
    if (xfer_s) begin
      req_pop[grant_id_r] = 1'b1;
      out_push            = 1'b1;
      out_data            = req_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      req_pop  = '0;
      out_push = 1'b0;
      out_data = '0;
    end
  end

  // Grant status comes straight from flops; the reset cycle forces it to zero.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (rst) begin
      grant_valid = 1'b0;
      grant_id    = '0;
    end else begin
      grant_valid = (state_r == ST_GRANT);
      grant_id    = grant_id_r;
    end
  end

  // Next-state logic: arbitrate in IDLE, stream and release in GRANT.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    grant_id_nxt_s  = grant_id_r;
    burst_cnt_nxt_s = burst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_nxt_s     = ST_GRANT;
          grant_id_nxt_s  = sel_id_s;
          burst_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (xfer_s) begin
          burst_cnt_nxt_s = burst_cnt_r + 4'd1;
          if (burst_cnt_r == 4'(MAX_BURST - 1)) begin
            state_nxt_s  = ST_IDLE;
            rr_ptr_nxt_s = id_inc_s;
          end else begin
            state_nxt_s = ST_GRANT;
          end
        end else if (req_empty[grant_id_r]) begin
          // Source ran dry: give up the grant rather than wait for refill.
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = id_inc_s;
        end else begin
          // Downstream full: hold the grant and stall.
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_id_r  <= grant_id_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that shares one downstream FIFO among `NUM_REQ` upstream FIFOs in the router. It watches the upstream `empty` flags, grants one requester at a time, and moves words from it with paired pop/push strobes. Each grant is bounded by a burst limit so no input can starve the others. Upstream FIFOs supply `pop_data` combinationally for the current head entry; the downstream FIFO accepts data on `push`.

## Interface
- `NUM_REQ`, default 4: number of upstream FIFOs, 2..8.
- `DATA_WIDTH`, default 8: word width.
- `MAX_BURST`, default 4: maximum words per grant, 1..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_empty`  in  NUM_REQ  `empty` flag of each upstream FIFO.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed head data; requester i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_pop`  out  NUM_REQ  pop strobe to each upstream FIFO; at most one bit set.
- `out_full`  in  1  `full` flag of the downstream FIFO.
- `out_push`  out  1  push strobe to the downstream FIFO.
- `out_data`  out  DATA_WIDTH  push data.
- `grant_valid`  out  1  high while in GRANT.
- `grant_id`  out  $clog2(NUM_REQ)  current or last granted requester.

## Operation
- State machine with two states, IDLE and GRANT. Internal registers:
  - `rr_ptr`: highest-priority requester.
  - `grant_id`.
  - `burst_cnt`: 4 bits.
- IDLE:
  - If any `req_empty` bit is 0, select the first non-empty requester scanning `rr_ptr`, `rr_ptr+1`, ... modulo `NUM_REQ`.
  - Register it into `grant_id`, clear `burst_cnt`, go to GRANT.
  - Otherwise stay in IDLE. No pop or push is issued in IDLE.
- GRANT transfer condition: `xfer = !req_empty[grant_id] && !out_full`.
- On `xfer`, all in the same cycle:
  - `req_pop[grant_id]=1`.
  - `out_push=1`.
  - `out_data=req_data[grant_id]`.
  - `burst_cnt` increments.
- When `xfer` is low: all `req_pop`=0, `out_push`=0, `out_data`=0.
- Release from GRANT to IDLE, with `rr_ptr` set to `grant_id+1`, wrapping from `NUM_REQ-1` to 0:
  - (a) on `xfer` when `burst_cnt==MAX_BURST-1`, so the burst completes; or
  - (b) when `req_empty[grant_id]==1`.
- `out_full` alone never releases a grant. The arbiter stalls, holding the grant, until space frees.
- The arbiter never pops an empty FIFO and never pushes a full FIFO. The push-while-full-with-pop case is deliberately not used.
- Reset has priority over everything, including mid-burst. On reset:
  - state=IDLE, `rr_ptr`=0, `grant_id`=0, `burst_cnt`=0.
  - All outputs are 0 in the reset cycle and in the first cycle after it.

## Timing
- Arbitration latency: requester non-empty in IDLE at cycle N, `grant_valid`=1 at N+1, first pop/push at N+1 if `out_full`=0.
- Within GRANT, transfers are back-to-back, one word per cycle.
- Each grant is followed by exactly one IDLE bubble cycle. The steady-state rate with all requesters loaded is `MAX_BURST` words per `MAX_BURST+1` cycles.
- `req_pop`, `out_push` and `out_data` are combinational from state and inputs. `grant_valid` and `grant_id` are registered.
- An upstream FIFO that goes empty mid-burst releases the grant the following cycle: one cycle in GRANT with no transfer, then IDLE.
- Pointer wrap: a grant to requester `NUM_REQ-1` sets `rr_ptr`=0.
- Fairness: a continuously non-empty requester is granted within `NUM_REQ-1` grants of any other requester.

## Test plan
- **Single requester:** `NUM_REQ`=4, `MAX_BURST`=4; only FIFO 2 holds 3 words A,B,C.
  - Required: `grant_id`=2 one cycle after, pushes A,B,C on consecutive cycles.
  - Then one no-transfer GRANT cycle, then IDLE with `rr_ptr`=3.
- **Round-robin order and burst limit:** all 4 FIFOs hold 5 words.
  - Required grant order 0,1,2,3,0,1,2,3, with 4 pushes per first-round grant and 1 per second-round grant.
  - One idle bubble between grants.
  - Downstream receives 20 words, each upstream's order preserved.
- **Wrap-around priority:** `rr_ptr`=3 with FIFOs 0 and 3 non-empty.
  - Required: grant to 3 first, then 0.
- **Backpressure:** during a grant to FIFO 1, hold `out_full`=1 for 3 cycles after the second word.
  - Required: `out_push`=0 and `req_pop`=0 for those 3 cycles, grant held at 1.
  - Remaining 2 words delivered after `out_full` drops. Total still 4 words.
- **Reset mid-burst:** assert `rst` for 1 cycle after 2 words of a grant to FIFO 2.
  - Required: outputs 0 in the reset cycle and the next, `grant_valid`=0.
  - Next grant goes to the lowest-index non-empty FIFO, since `rr_ptr`=0.
  - No word is duplicated or lost across the reset.
